// File: rtl/mc_mem_pkg.sv
// Shared constants and types for the multi-core memory arbiter.
package mc_mem_pkg;

  localparam int unsigned N_CORES    = 4;
  localparam int unsigned WIDTH      = 12;
  localparam int unsigned DEPTH      = 256;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CORE_W     = $clog2(N_CORES);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef logic [CORE_W-1:0] core_id_t;

  // Successor in round-robin order, wrapping N_CORES-1 -> 0.
  function automatic core_id_t next_core(input core_id_t i);
    if (i == core_id_t'(N_CORES - 1)) begin
      return '0;
    end
    return i + core_id_t'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first masked request at or after base.
module rr_picker
  import mc_mem_pkg::*;
(
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] mask,
  input  core_id_t           base,
  output logic [N_CORES-1:0] gnt,
  output core_id_t           idx,
  output logic               valid
);

  logic [N_CORES-1:0] eligible;
  core_id_t           cand;

  assign eligible = req & mask;

  always_comb begin
    valid = 1'b0;
    idx   = base;
    cand  = base;
    for (int k = 0; k < N_CORES; k++) begin
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = next_core(cand);
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_CORES; i++) begin
      gnt[i] = valid && (idx == core_id_t'(i));
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between cores, with short
// grant locking for atomic read-modify-write sequences.
module ram_arbiter
  import mc_mem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [N_CORES-1:0]            req,
  input  logic [N_CORES-1:0]            lock,
  input  logic [N_CORES-1:0]            wrEn,
  input  logic [N_CORES*ADDR_WIDTH-1:0] addr,
  input  logic [N_CORES*WIDTH-1:0]      dataIn,
  output logic [N_CORES-1:0]            gnt,
  output logic [N_CORES-1:0]            rdValid,
  output logic [WIDTH-1:0]              rdData,
  output logic                          ram_wrEn,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [WIDTH-1:0]              ram_dataIn,
  input  logic [WIDTH-1:0]              ram_dataOut
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  core_id_t           rr_ptr_q, rr_ptr_d;
  core_id_t           owner_q, owner_d;
  lock_state_e        state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [N_CORES-1:0] rd_valid_q, rd_valid_d;

  logic [ADDR_WIDTH-1:0] addr_arr [N_CORES];
  logic [WIDTH-1:0]      data_arr [N_CORES];

  logic               hold;
  core_id_t           base;
  logic [N_CORES-1:0] mask;
  logic [N_CORES-1:0] pick_gnt;
  core_id_t           pick_idx;
  logic               pick_valid;
  core_id_t           sel;
  logic               any;
  logic               active;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      addr_arr[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = dataIn[i*WIDTH +: WIDTH];
    end
  end

  // Locked owner keeps the RAM while it still asks and the budget lasts.
  assign hold = (state_q == LOCKED) && req[owner_q] && lock[owner_q] &&
                (lock_cnt_q < CNT_W'(LOCK_MAX));

  // On release the owner is skipped and the search starts just past it.
  always_comb begin
    mask = '1;
    base = rr_ptr_q;
    if (state_q == LOCKED) begin
      mask[owner_q] = 1'b0;
      base          = next_core(owner_q);
    end
  end

  rr_picker u_rr_picker (
    .req   (req),
    .mask  (mask),
    .base  (base),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign sel    = hold ? owner_q : pick_idx;
  assign any    = hold | pick_valid;
  assign active = any & rstN;

  always_comb begin
    gnt = '0;
    if (rstN) begin
      gnt = hold ? '0 : pick_gnt;
      if (hold) begin
        gnt[owner_q] = 1'b1;
      end
    end
  end

  assign ram_wrEn   = active & wrEn[sel];
  assign ram_addr   = active ? addr_arr[sel] : '0;
  assign ram_dataIn = active ? data_arr[sel] : '0;
  assign rdValid    = rd_valid_q;
  assign rdData     = ram_dataOut;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rd_valid_d = '0;
    if (any && !wrEn[sel]) begin
      rd_valid_d[sel] = 1'b1;
    end
    if (hold) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else begin
      state_d    = UNLOCKED;
      lock_cnt_d = '0;
      if (state_q == LOCKED) begin
        rr_ptr_d = next_core(owner_q);
      end
      if (pick_valid) begin
        if (lock[pick_idx]) begin
          state_d    = LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = CNT_W'(1);
        end else begin
          rr_ptr_d = next_core(pick_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      rd_valid_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a queue-free behavioural arbiter model
// and a simple synchronous RAM hanging off the ram_* port.
module tb_ram_arbiter;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 12;
  localparam int LMAX = 4;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NC-1:0]     req, lock, wrEn;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  dataIn;
  logic [NC-1:0]     gnt, rdValid;
  logic [DW-1:0]     rdData;
  logic              ram_wrEn;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_dataIn;
  logic [DW-1:0]     ram_dataOut;

  ram_arbiter #(.LOCK_MAX(LMAX)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .req         (req),
    .lock        (lock),
    .wrEn        (wrEn),
    .addr        (addr),
    .dataIn      (dataIn),
    .gnt         (gnt),
    .rdValid     (rdValid),
    .rdData      (rdData),
    .ram_wrEn    (ram_wrEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut)
  );

  always #5 clk = ~clk;

  // External RAM: sync write, registered read address.
  logic [DW-1:0] mem [256];
  logic [AW-1:0] mem_raddr = '0;
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
    mem_raddr <= ram_addr;
  end
  assign ram_dataOut = mem[mem_raddr];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core-side stimulus state.
  bit            pend [NC];
  bit            we   [NC];
  bit            lk   [NC];
  logic [AW-1:0] ad   [NC];
  logic [DW-1:0] di   [NC];

  // Reference model state.
  int            m_rr, m_owner, m_cnt;
  logic [NC-1:0] m_rdv;
  logic [DW-1:0] m_rdd;
  logic [DW-1:0] shadow [256];

  // Last sampled DUT outputs.
  logic [NC-1:0] s_gnt, s_rdv;
  logic [DW-1:0] s_rdd;
  logic          s_wr;

  function automatic int model_pick(output bit cont);
    int start;
    cont = 0;
    if (m_owner >= 0 && pend[m_owner] && lk[m_owner] && m_cnt < LMAX) begin
      cont = 1;
      return m_owner;
    end
    start = (m_owner >= 0) ? (m_owner + 1) % NC : m_rr;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (start + k) % NC;
      if (c != m_owner && pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      req[c]             = pend[c];
      lock[c]            = lk[c];
      wrEn[c]            = we[c];
      addr[c*AW +: AW]   = ad[c];
      dataIn[c*DW +: DW] = di[c];
    end
  endtask

  // One clock cycle: drive, sample at negedge, advance model at posedge.
  task automatic step(input bit rst, output int g);
    bit cont;
    logic [NC-1:0] eg;
    drive();
    rstN = !rst;
    if (rst) m_rdv = '0;
    g = -1;
    @(negedge clk);
    s_gnt = gnt; s_rdv = rdValid; s_rdd = rdData; s_wr = ram_wrEn;
    check_eq("rdValid", rdValid, m_rdv);
    if (m_rdv != 0) check_eq("rdData", rdData, m_rdd);
    if (rst) begin
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_wrEn", ram_wrEn, 0);
    end else begin
      g  = model_pick(cont);
      eg = (g >= 0) ? (NC'(1) << g) : '0;
      check_eq("gnt", gnt, eg);
      check_eq("ram_wrEn", ram_wrEn, (g >= 0) ? we[g] : 1'b0);
      check_eq("ram_addr", ram_addr, (g >= 0) ? ad[g] : '0);
      check_eq("ram_dataIn", ram_dataIn, (g >= 0) ? di[g] : '0);
    end
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_owner = -1; m_cnt = 0; m_rdv = '0;
    end else begin
      m_rdv = '0;
      if (g >= 0) begin
        if (we[g]) shadow[ad[g]] = di[g];
        else begin
          m_rdv = NC'(1) << g;
          m_rdd = shadow[ad[g]];
        end
      end
      if (cont) m_cnt++;
      else begin
        if (m_owner >= 0) m_rr = (m_owner + 1) % NC;
        m_owner = -1; m_cnt = 0;
        if (g >= 0) begin
          if (lk[g]) begin m_owner = g; m_cnt = 1; end
          else m_rr = (g + 1) % NC;
        end
      end
    end
    #1;
  endtask

  task automatic new_op(input int c, input bit force_lock);
    pend[c] = 1;
    we[c]   = 1'($urandom_range(1));
    ad[c]   = AW'($urandom_range(15));
    di[c]   = DW'($urandom);
    lk[c]   = force_lock ? 1'b1 : ($urandom_range(3) == 0);
  endtask

  task automatic idle_all();
    for (int c = 0; c < NC; c++) begin
      pend[c] = 0; we[c] = 0; lk[c] = 0; ad[c] = '0; di[c] = '0;
    end
  endtask

  initial begin
    int g;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = DW'($urandom);
      shadow[i] = mem[i];
    end
    m_rr = 0; m_owner = -1; m_cnt = 0; m_rdv = '0; m_rdd = '0;
    idle_all();

    // Reset with all cores requesting.
    for (int c = 0; c < NC; c++) pend[c] = 1;
    step(1, g);
    step(1, g);

    // All four read, expect strict rotation from core 0.
    for (int c = 0; c < NC; c++) begin
      pend[c] = 1; ad[c] = AW'(8'h20 + c);
    end
    for (int i = 0; i < NC; i++) begin
      step(0, g);
      check_eq("t2_gnt", s_gnt, NC'(1) << i);
      if (g >= 0) pend[g] = 0;
    end
    step(0, g);
    check_eq("t2_last_rdv", s_rdv, 4'b1000);

    // Write then read the same address on consecutive cycles.
    pend[1] = 1; we[1] = 1; ad[1] = 8'h10; di[1] = 12'hABC;
    step(0, g);
    check_eq("t3_wr", s_wr, 1);
    pend[1] = 0; we[1] = 0;
    pend[2] = 1; we[2] = 0; ad[2] = 8'h10;
    step(0, g);
    pend[2] = 0;
    step(0, g);
    check_eq("t3_rdv", s_rdv, 4'b0100);
    check_eq("t3_rdd", s_rdd, 12'hABC);

    // Lock budget exhaustion then round-robin wrap back to core 0.
    step(1, g);
    pend[0] = 1; lk[0] = 1; ad[0] = 8'h05;
    pend[3] = 1; ad[3] = 8'h06;
    for (int i = 0; i < 6; i++) begin
      step(0, g);
      check_eq("t4_gnt", s_gnt, (i == 4) ? 4'b1000 : 4'b0001);
      if (g == 3) pend[3] = 0;
    end
    idle_all();

    // Reset right after a read grant kills the pending rdValid.
    step(1, g);
    pend[2] = 1; ad[2] = 8'h30;
    step(0, g);
    check_eq("t5_gnt", s_gnt, 4'b0100);
    pend[2] = 0;
    step(1, g);
    check_eq("t5_rdv_rst", s_rdv, 0);
    step(0, g);
    check_eq("t5_rdv_after", s_rdv, 0);

    // Withdrawn request leaves no trace; pointer sits at core 2.
    pend[1] = 1; pend[3] = 1;
    step(0, g);
    check_eq("t6_gnt1", s_gnt, 4'b0010);
    pend[1] = 0; pend[3] = 0;
    step(0, g);
    check_eq("t6_none", s_gnt, 0);
    check_eq("t6_nowr", s_wr, 0);
    pend[0] = 1; pend[2] = 1; pend[3] = 1;
    step(0, g);
    check_eq("t6_gnt2", s_gnt, 4'b0100);
    idle_all();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit rst;
      rst = ($urandom_range(249) == 0);
      step(rst, g);
      if (!rst) begin
        for (int c = 0; c < NC; c++) begin
          if (c == g) begin
            if (lk[c] && $urandom_range(3) != 0) new_op(c, 1'b1);
            else pend[c] = 0;
          end else if (pend[c]) begin
            if ($urandom_range(15) == 0) pend[c] = 0;
          end else if ($urandom_range(1) == 0) begin
            new_op(c, 1'b0);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
